// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_pkg                                                                     |
// | Shared types and constants for the Y86-64 data-memory arbiter.               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic REQ_M = 1'b0;
  localparam logic REQ_L = 1'b1;

  localparam int DMEM_DEPTH = 1024;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb2                                                                      |
// | Combinational two-way round-robin arbiter producing a one-hot grant.        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       i_req_m,
  input  logic       i_req_l,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req_m && i_req_l) begin
      // On a tie the requester that was not served last takes the slot.
      if (i_last_gnt == REQ_L) begin
        o_gnt[REQ_M] = 1'b1;
      end else begin
        o_gnt[REQ_L] = 1'b1;
      end
    end else if (i_req_m) begin
      o_gnt[REQ_M] = 1'b1;
    end else if (i_req_l) begin
      o_gnt[REQ_L] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter                                                                 |
// | Serialises memory-stage and loader accesses onto the single-ported dmem.    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m_req,
  input  logic          m_we,
  input  logic [63:0]   m_addr,
  input  logic [63:0]   m_wdata,
  output logic          m_gnt,
  output logic          m_rvalid,
  output logic [63:0]   m_rdata,
  output logic          m_err,

  input  logic          l_req,
  input  logic          l_we,
  input  logic [63:0]   l_addr,
  input  logic [63:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [63:0]   l_rdata,
  output logic          l_err,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,

  output logic          dmem_err
);

  localparam logic [63:0] c_DEPTH64 = 64'(DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_latch;
  logic        w_resp;
  logic [1:0]  w_gnt;

  logic        r_owner;
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_last_gnt;

  logic        r_m_gnt, r_m_rvalid, r_m_err;
  logic        r_l_gnt, r_l_rvalid, r_l_err;
  logic [63:0] r_m_rdata, r_l_rdata;
  logic        r_dmem_err;

  logic        w_in_range;
  logic        w_issue_ok;
  logic        w_rd_ok;
  logic        w_owner_nxt;

  rr_arb2 u_arb (
    .i_req_m    (m_req),
    .i_req_l    (l_req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt)
  );

  assign w_owner_nxt = w_gnt[REQ_L] ? REQ_L : REQ_M;
  assign w_in_range  = (r_addr < c_DEPTH64);
  assign w_issue_ok  = (r_state == ISSUE) && w_in_range;
  assign w_rd_ok     = w_in_range && !r_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt != 2'b00) begin
          w_latch     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = RESP;
      RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= REQ_M;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_last_gnt <= REQ_L;
      r_m_gnt    <= 1'b0;
      r_l_gnt    <= 1'b0;
      r_m_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_m_rdata  <= '0;
      r_l_rdata  <= '0;
      r_m_err    <= 1'b0;
      r_l_err    <= 1'b0;
      r_dmem_err <= 1'b0;
    end else begin
      if (w_latch) begin
        r_owner    <= w_owner_nxt;
        r_last_gnt <= w_owner_nxt;
        r_we       <= (w_owner_nxt == REQ_L) ? l_we    : m_we;
        r_addr     <= (w_owner_nxt == REQ_L) ? l_addr  : m_addr;
        r_wdata    <= (w_owner_nxt == REQ_L) ? l_wdata : m_wdata;
      end
      r_m_gnt    <= w_latch && (w_owner_nxt == REQ_M);
      r_l_gnt    <= w_latch && (w_owner_nxt == REQ_L);
      r_m_rvalid <= w_resp && (r_owner == REQ_M);
      r_l_rvalid <= w_resp && (r_owner == REQ_L);
      // Response fields are only non-zero alongside the owner's rvalid pulse.
      r_m_rdata  <= (w_resp && (r_owner == REQ_M) && w_rd_ok) ? mem_rdata : '0;
      r_l_rdata  <= (w_resp && (r_owner == REQ_L) && w_rd_ok) ? mem_rdata : '0;
      r_m_err    <= w_resp && (r_owner == REQ_M) && !w_in_range;
      r_l_err    <= w_resp && (r_owner == REQ_L) && !w_in_range;
      if (w_resp && !w_in_range) begin
        r_dmem_err <= 1'b1;
      end
    end
  end

  assign mem_en    = w_issue_ok;
  assign mem_we    = w_issue_ok && r_we;
  assign mem_addr  = w_issue_ok ? r_addr[AW-1:0] : '0;
  assign mem_wdata = w_issue_ok ? r_wdata : '0;

  assign m_gnt    = r_m_gnt;
  assign m_rvalid = r_m_rvalid;
  assign m_rdata  = r_m_rdata;
  assign m_err    = r_m_err;
  assign l_gnt    = r_l_gnt;
  assign l_rvalid = r_l_rvalid;
  assign l_rdata  = r_l_rdata;
  assign l_err    = r_l_err;
  assign dmem_err = r_dmem_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter                                                              |
// | Scoreboard-based bench for dmem_arbiter with a behavioural memory model.    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_req = 1'b0, m_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0, l_addr = '0, l_wdata = '0;
  logic        m_gnt, m_rvalid, m_err, l_gnt, l_rvalid, l_err;
  logic [63:0] m_rdata, l_rdata;
  logic        mem_en, mem_we, dmem_err;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;

  typedef struct packed {
    logic        owner;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem_model [0:1023];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External synchronous-read memory.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      mem_rdata <= mem_model[mem_addr];
    end
  end

  function automatic logic [131:0] resp_vec(input exp_t e);
    if (e.owner == 1'b0) return {1'b1, 1'b0, e.err, 1'b0, e.rdata, 64'd0};
    else                 return {1'b0, 1'b1, 1'b0, e.err, 64'd0, e.rdata};
  endfunction

  function automatic logic [266:0] all_outs();
    return {m_gnt, m_rvalid, m_rdata, m_err, l_gnt, l_rvalid, l_rdata, l_err,
            mem_en, mem_we, mem_addr, mem_wdata, dmem_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(output int at);
    at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_rvalid || l_rvalid) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_gnt(output int at);
    at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_gnt || l_gnt) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_m_write();
    int t0, t;
    exp_t e;
    step();
    t0 = cyc;
    m_req = 1'b1; m_we = 1'b1; m_addr = 64'd5; m_wdata = 64'hDEAD;
    sb.push_back('{owner: 1'b0, rdata: 64'd0, err: 1'b0});
    @(negedge clk); @(negedge clk);
    checks++;
    if ({m_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 10'd5, 64'hDEAD}) begin
      failures++;
      $display("FAIL write_issue: got gnt=%b/%b en=%b we=%b addr=%0d wdata=%h want 1/0 1 1 5 dead",
               m_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    m_req = 1'b0;
    wait_rvalid(t);
    checks++;
    if (t != t0 + 3) begin
      failures++;
      $display("FAIL write_latency: rvalid at cycle %0d want %0d", t, t0 + 3);
    end
    e = sb.pop_front();
    checks++;
    if ({m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e)) begin
      failures++;
      $display("FAIL write_resp: got %h want %h",
               {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, resp_vec(e));
    end
  endtask

  task automatic test_m_read();
    int t0, t;
    exp_t e;
    step();
    t0 = cyc;
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'd5;
    sb.push_back('{owner: 1'b0, rdata: 64'hDEAD, err: 1'b0});
    wait_gnt(t);
    checks++;
    if (t != t0 + 1 || {m_gnt, l_gnt, mem_en, mem_we} !== 4'b1010) begin
      failures++;
      $display("FAIL read_gnt: cycle %0d gnt=%b/%b en=%b we=%b want cycle %0d 1/0 1 0",
               t, m_gnt, l_gnt, mem_en, mem_we, t0 + 1);
    end
    step();
    m_req = 1'b0;
    wait_rvalid(t);
    e = sb.pop_front();
    checks++;
    if (t != t0 + 3 || {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e)) begin
      failures++;
      $display("FAIL read_resp: cycle %0d got %h want cycle %0d %h", t,
               {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, t0 + 3, resp_vec(e));
    end
  endtask

  task automatic test_out_of_range();
    int t0, t;
    exp_t e;
    // M read whose low address bits alias word 5 must still be rejected.
    step();
    t0 = cyc;
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h1_0000_0005;
    sb.push_back('{owner: 1'b0, rdata: 64'd0, err: 1'b1});
    wait_gnt(t);
    checks++;
    if (t != t0 + 1 || {m_gnt, mem_en} !== 2'b10) begin
      failures++;
      $display("FAIL oor_alias_issue: cycle %0d gnt=%b en=%b want cycle %0d 1 0", t, m_gnt, mem_en, t0 + 1);
    end
    step();
    m_req = 1'b0;
    wait_rvalid(t);
    e = sb.pop_front();
    checks++;
    if ({m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e) || dmem_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_alias_resp: got %h dmem_err=%b want %h 1",
               {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, dmem_err, resp_vec(e));
    end
    // L write just past the end of memory.
    step();
    t0 = cyc;
    l_req = 1'b1; l_we = 1'b1; l_addr = 64'd1024; l_wdata = 64'hBAD;
    sb.push_back('{owner: 1'b1, rdata: 64'd0, err: 1'b1});
    wait_gnt(t);
    checks++;
    if (t != t0 + 1 || {l_gnt, m_gnt, mem_en, mem_we} !== 4'b1000) begin
      failures++;
      $display("FAIL oor_write_issue: cycle %0d gnt=%b/%b en=%b we=%b want cycle %0d 1/0 0 0",
               t, l_gnt, m_gnt, mem_en, mem_we, t0 + 1);
    end
    step();
    l_req = 1'b0;
    wait_rvalid(t);
    e = sb.pop_front();
    checks++;
    if (t != t0 + 3 || {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e)
        || dmem_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_write_resp: cycle %0d got %h dmem_err=%b want %h 1", t,
               {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, dmem_err, resp_vec(e));
    end
  endtask

  task automatic test_round_robin();
    int tprev, t;
    exp_t e;
    step();
    tprev = cyc;
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'd5;
    l_req = 1'b1; l_we = 1'b1; l_addr = 64'd7; l_wdata = 64'h77;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{owner: 1'(i % 2), rdata: (i % 2 == 0) ? 64'hDEAD : 64'd0, err: 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      wait_gnt(t);
      checks++;
      if ({m_gnt, l_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || t != tprev + ((i == 0) ? 1 : 3)) begin
        failures++;
        $display("FAIL rr_gnt%0d: cycle %0d m/l=%b%b want cycle %0d owner %s",
                 i, t, m_gnt, l_gnt, tprev + ((i == 0) ? 1 : 3), (i % 2 == 0) ? "M" : "L");
      end
      tprev = t;
      if (i == 5) begin
        step();
        m_req = 1'b0;
        l_req = 1'b0;
      end
      wait_rvalid(t);
      e = sb.pop_front();
      checks++;
      if (t != tprev + 2 || {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e)) begin
        failures++;
        $display("FAIL rr_resp%0d: cycle %0d got %h want cycle %0d %h", i, t,
                 {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, tprev + 2, resp_vec(e));
      end
    end
    checks++;
    if (dmem_err !== 1'b1) begin
      failures++;
      $display("FAIL sticky_err: dmem_err=%b want 1", dmem_err);
    end
  endtask

  task automatic test_reset_mid_access();
    int t0, t, seen;
    exp_t e;
    step();
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'd5;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h want 0", all_outs());
    end
    m_req = 1'b0;
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (m_rvalid || l_rvalid || m_gnt || l_gnt) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_abandon: saw %0d handshake cycles want 0", seen);
    end
    step();
    t0 = cyc;
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'd7;
    sb.push_back('{owner: 1'b1, rdata: 64'h77, err: 1'b0});
    wait_gnt(t);
    checks++;
    if (t != t0 + 1 || {m_gnt, l_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_gnt: cycle %0d m/l=%b%b want cycle %0d 01", t, m_gnt, l_gnt, t0 + 1);
    end
    step();
    l_req = 1'b0;
    wait_rvalid(t);
    e = sb.pop_front();
    checks++;
    if ({m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e) || dmem_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_resp: got %h dmem_err=%b want %h 0",
               {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, dmem_err, resp_vec(e));
    end
  endtask

  task automatic test_late_request();
    int t0, t;
    exp_t e;
    step();
    t0 = cyc;
    m_req = 1'b1; m_we = 1'b1; m_addr = 64'd9; m_wdata = 64'h99;
    sb.push_back('{owner: 1'b0, rdata: 64'd0, err: 1'b0});
    step();
    m_req = 1'b0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'd9;
    sb.push_back('{owner: 1'b1, rdata: 64'h99, err: 1'b0});
    wait_rvalid(t);
    e = sb.pop_front();
    checks++;
    if (t != t0 + 3 || {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e)) begin
      failures++;
      $display("FAIL late_m_resp: cycle %0d got %h want cycle %0d %h", t,
               {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, t0 + 3, resp_vec(e));
    end
    wait_gnt(t);
    checks++;
    if (t != t0 + 4 || {m_gnt, l_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL late_l_gnt: cycle %0d m/l=%b%b want cycle %0d 01", t, m_gnt, l_gnt, t0 + 4);
    end
    step();
    l_req = 1'b0;
    wait_rvalid(t);
    e = sb.pop_front();
    checks++;
    if (t != t0 + 6 || {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata} !== resp_vec(e)) begin
      failures++;
      $display("FAIL late_l_resp: cycle %0d got %h want cycle %0d %h", t,
               {m_rvalid, l_rvalid, m_err, l_err, m_rdata, l_rdata}, t0 + 6, resp_vec(e));
    end
  endtask

  initial begin
    test_reset();
    test_m_write();
    test_m_read();
    test_out_of_range();
    test_round_robin();
    test_reset_mid_access();
    test_late_request();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and two-way arbiter for the single-ported data memory of the Y86-64 processor. It shares the 1024-word data memory between the memory stage (requester M) and the program loader/debug port (requester L). Each access is serialised through a three-state FSM, out-of-range addresses are rejected, and the block reports both a per-access error and a sticky `dmem_err` flag.

## Interface
- `DEPTH`, 1024: number of 64-bit words in the data memory; valid addresses are 0..DEPTH-1.
- `AW`, 10: memory-side address width, equal to clog2(DEPTH).

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `m_req` in 1: M request.
- `m_we` in 1: M write enable.
- `m_addr` in 64: M word address.
- `m_wdata` in 64: M write data.
- `m_gnt` out 1: M grant, a one-cycle pulse.
- `m_rvalid` out 1: M completion, a one-cycle pulse; asserted for writes too.
- `m_rdata` out 64: M read data.
- `m_err` out 1: M access error, valid when `m_rvalid` is high.
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_gnt`, `l_rvalid`, `l_rdata`, `l_err`: same as the M signals, for requester L.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory word address.
- `mem_wdata` out 64: memory write data.
- `mem_rdata` in 64: memory read data; synchronous read, valid the cycle after `mem_en`.
- `dmem_err` out 1: sticky error flag; set by any out-of-range access, cleared only by reset.

## Operation
- FSM states:
  - IDLE: no access in flight; arbitrate.
  - ISSUE: drive the memory for one cycle.
  - RESP: capture the read data and respond to the owner.
- IDLE, when any request is present:
  - Pick the owner and latch its `we`, `addr` and `wdata`.
  - Register the owner's `gnt`.
  - Go to ISSUE.
- IDLE with no request: stay in IDLE.
- Arbitration:
  - Only one request present: that requester wins.
  - Both present: the requester not granted last wins (round-robin).
  - `last_gnt` resets to L, so M wins the first tie.
- ISSUE:
  - In range (`addr` < DEPTH): `mem_en`=1; `mem_we`, `mem_addr` (= `addr[AW-1:0]`) and `mem_wdata` come from the latched values.
  - Out of range: `mem_en`=0 and the write is dropped.
  - Always go to RESP.
- RESP:
  - `rdata` captures `mem_rdata` for an in-range read; otherwise 0.
  - `err` is set when the address is out of range.
  - `rvalid` is pulsed to the owner only.
  - `dmem_err` is set if `err` is set.
  - Go to IDLE.
- Requester rules:
  - Hold `req` and all request fields until `gnt` is seen.
  - Deassert `req` in the cycle after `gnt`, unless another access is wanted.
  - A `req` still high when IDLE is re-entered is treated as a new access.
- Non-owner outputs stay 0 throughout.

## Timing
- Reset values:
  - All outputs are 0, including `mem_*`, `gnt`, `rvalid`, `rdata`, `err` and `dmem_err`.
  - State is IDLE and `last_gnt` is L.
- All `gnt`, `rvalid`, `rdata` and `err` outputs are registered. `mem_*` outputs are decoded from the state register and the latched fields.
- Cycle-level timeline, with `req` sampled in IDLE at cycle 0:
  - Cycle 1: `gnt` is high and the FSM is in ISSUE (`mem_en` high).
  - Cycle 2: RESP.
  - Cycle 3: `rvalid` is high and the FSM is back in IDLE.
- Latency is 3 cycles from request to response. Throughput is one access per 3 cycles.
- A request held through cycle 3 produces its next `gnt` in cycle 4.
- Reset asserted mid-access:
  - State returns to IDLE immediately and asynchronously.
  - The in-flight access is abandoned with no `rvalid`.
  - A write already strobed in ISSUE is not undone.
- Requests arriving while the FSM is in ISSUE or RESP are ignored until IDLE.

## Structure
- Package `dmem_pkg`:
  - State enum: IDLE, ISSUE, RESP.
  - Requester IDs: `REQ_M`=0, `REQ_L`=1.
  - `DMEM_DEPTH`=1024.
- Sub-module `rr_arb2`:
  - Inputs: two requests and `last_gnt`.
  - Output: one-hot grant.
  - Purely combinational; the `last_gnt` register lives in `dmem_arbiter`.
- The memory array is external to this block.

## Test plan
- Reset, then M write at `addr`=5 with data 0xDEAD → `m_gnt` in cycle 1, `mem_en`=`mem_we`=1 with `mem_addr`=5 in cycle 1, `m_rvalid`=1 with `m_err`=0 in cycle 3.
- M read at `addr`=5 after that write → `m_rdata`=0xDEAD with `m_rvalid` in cycle 3; L outputs stay 0.
- `m_req` and `l_req` held together for 6 accesses → grants alternate M, L, M, L, M, L, one per 3 cycles.
- L write at `addr`=1024 → `mem_en` stays 0, `l_err`=1, `l_rdata`=0, and `dmem_err` rises and stays 1 through later good accesses.
- `rst_n` pulsed low during ISSUE of an M read → all outputs 0 at once, no `m_rvalid`, and a new `l_req` is granted normally after release.
- `l_req` raised in the cycle after `m_gnt` → ignored until IDLE, then `l_gnt` in cycle 4.
